// File: rtl/sensor_pkg.sv
// Shared definitions for the DHT11 sensor-to-memory bridge:
// window offsets, status bit layout and bridge state encoding.
package sensor_pkg;

   localparam logic [15:0] HUM_OFS  = 16'd0;
   localparam logic [15:0] TMP_OFS  = 16'd1;
   localparam logic [15:0] CNT_OFS  = 16'd2;
   localparam logic [15:0] STAT_OFS = 16'd3;

   localparam int VALID_BIT   = 0;
   localparam int OVERRUN_BIT = 1;
   localparam int STALE_BIT   = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_HUM  = 3'd1,
      ST_WR_TMP  = 3'd2,
      ST_WR_CNT  = 3'd3,
      ST_WR_STAT = 3'd4,
      ST_DONE    = 3'd5
   } state_e;

   function automatic logic [15:0] status_word(
      input logic stale,
      input logic overrun,
      input logic valid
   );
      logic [15:0] w;
      w              = '0;
      w[STALE_BIT]   = stale;
      w[OVERRUN_BIT] = overrun;
      w[VALID_BIT]   = valid;
      return w;
   endfunction

endpackage

// File: rtl/sensor_stale_timer.sv
// Saturating cycle counter since the last captured reading;
// stale is high while the counter sits at its limit.
module sensor_stale_timer #(
   parameter int unsigned LIMIT = 300_000_000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clr,
   output logic stale
);

   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] MAX = W'(LIMIT);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Clear on capture, otherwise count up and hold at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (cnt_q != MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stale = (cnt_q == MAX);

endmodule

// File: rtl/sensor_mem_bridge.sv
// Copies each DHT11 reading, a sample count and a status word
// into a 4-word memory window, then pulses irq.
module sensor_mem_bridge
   import sensor_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR    = 16'hFF00,
   parameter int unsigned STALE_CYCLES = 300_000_000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [15:0] sensor_data,
   input  logic        sensor_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_ack,
   output logic        irq,
   output logic        overrun,
   output logic        stale
);

   state_e      state_q, state_d;
   logic        ready_q, ready_d;
   logic [15:0] cap_q, cap_d;
   logic [15:0] pend_q, pend_d;
   logic        pending_q, pending_d;
   logic [15:0] sample_cnt_q, sample_cnt_d;
   logic        valid_q, valid_d;
   logic        overrun_q, overrun_d;
   logic        stale_reported_q, stale_reported_d;
   logic        mem_req_q, mem_req_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;
   logic        irq_q, irq_d;

   logic        new_rd;
   logic        ack;
   logic        busy;
   logic        load_cap;
   logic [15:0] cap_src;

   assign new_rd = sensor_ready & ~ready_q;
   assign ack    = mem_req_q & mem_ack;

   sensor_stale_timer #(
      .LIMIT(STALE_CYCLES)
   ) u_stale (
      .clock  (clock),
      .reset_n(reset_n),
      .clr    (load_cap),
      .stale  (stale)
   );

   // Next state, capture, buffering and status bookkeeping.
   always_comb begin
      state_d          = state_q;
      ready_d          = sensor_ready;
      cap_d            = cap_q;
      pend_d           = pend_q;
      pending_d        = pending_q;
      sample_cnt_d     = sample_cnt_q;
      valid_d          = valid_q;
      overrun_d        = overrun_q;
      stale_reported_d = stale_reported_q;
      load_cap         = 1'b0;
      cap_src          = sensor_data;
      busy             = (state_q inside
                          {ST_WR_HUM, ST_WR_TMP,
                           ST_WR_CNT, ST_WR_STAT});

      if (busy && new_rd) begin
         pend_d    = sensor_data;
         pending_d = 1'b1;
         if (pending_q) overrun_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (new_rd) begin
               load_cap = 1'b1;
               state_d  = ST_WR_HUM;
            end else if (stale && !stale_reported_q) begin
               state_d = ST_WR_STAT;
            end
         end
         ST_WR_HUM: if (ack) state_d = ST_WR_TMP;
         ST_WR_TMP: if (ack) state_d = ST_WR_CNT;
         ST_WR_CNT: if (ack) state_d = ST_WR_STAT;
         ST_WR_STAT: begin
            if (ack) begin
               state_d          = ST_DONE;
               stale_reported_d = stale;
               // A loss in this same cycle must stay visible.
               if (!(new_rd && pending_q)) overrun_d = 1'b0;
            end
         end
         ST_DONE: begin
            if (pending_q) begin
               load_cap  = 1'b1;
               cap_src   = pend_q;
               pending_d = new_rd;
               if (new_rd) pend_d = sensor_data;
               state_d   = ST_WR_HUM;
            end else if (new_rd) begin
               load_cap = 1'b1;
               state_d  = ST_WR_HUM;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load_cap) begin
         cap_d            = cap_src;
         sample_cnt_d     = sample_cnt_q + 16'd1;
         valid_d          = 1'b1;
         stale_reported_d = 1'b0;
      end
   end

   // Bus outputs are loaded on word entry and held until the next state change.
   always_comb begin
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      irq_d       = (state_d == ST_DONE);
      if (state_d != state_q) begin
         mem_req_d   = 1'b0;
         mem_addr_d  = '0;
         mem_wdata_d = '0;
         unique case (state_d)
            ST_WR_HUM: begin
               mem_req_d   = 1'b1;
               mem_addr_d  = BASE_ADDR + HUM_OFS;
               mem_wdata_d = {8'h00, cap_d[15:8]};
            end
            ST_WR_TMP: begin
               mem_req_d   = 1'b1;
               mem_addr_d  = BASE_ADDR + TMP_OFS;
               mem_wdata_d = {8'h00, cap_d[7:0]};
            end
            ST_WR_CNT: begin
               mem_req_d   = 1'b1;
               mem_addr_d  = BASE_ADDR + CNT_OFS;
               mem_wdata_d = sample_cnt_d;
            end
            ST_WR_STAT: begin
               mem_req_d   = 1'b1;
               mem_addr_d  = BASE_ADDR + STAT_OFS;
               mem_wdata_d = status_word(stale, overrun_d, valid_d);
            end
            default: ;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         ready_q          <= 1'b0;
         cap_q            <= '0;
         pend_q           <= '0;
         pending_q        <= 1'b0;
         sample_cnt_q     <= '0;
         valid_q          <= 1'b0;
         overrun_q        <= 1'b0;
         stale_reported_q <= 1'b0;
         mem_req_q        <= 1'b0;
         mem_addr_q       <= '0;
         mem_wdata_q      <= '0;
         irq_q            <= 1'b0;
      end else begin
         state_q          <= state_d;
         ready_q          <= ready_d;
         cap_q            <= cap_d;
         pend_q           <= pend_d;
         pending_q        <= pending_d;
         sample_cnt_q     <= sample_cnt_d;
         valid_q          <= valid_d;
         overrun_q        <= overrun_d;
         stale_reported_q <= stale_reported_d;
         mem_req_q        <= mem_req_d;
         mem_addr_q       <= mem_addr_d;
         mem_wdata_q      <= mem_wdata_d;
         irq_q            <= irq_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign irq       = irq_q;
   assign overrun   = overrun_q;

endmodule

// File: doc/sensor_mem_bridge.md
Name: sensor_mem_bridge

Overview:
- Sits directly downstream of the DHT11 sensor driver.
- Consumes its 16-bit reading (humidity integer in [15:8], temperature integer in [7:0]) and its level-type ready flag.
- Writes the reading, a sample count and a status word into four consecutive words of CPU data memory through a req/ack write port, then pulses an interrupt.
- Buffers one reading that arrives while a write burst is in flight, and flags a stale sensor.

Parameters:
- BASE_ADDR, 16'hFF00, address of word 0 of the 4-word sensor window.
- STALE_CYCLES, 300_000_000, cycles without a new reading before stale is declared (3 s at 100 MHz).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- sensor_data  in  16  reading from the sensor driver; stable while sensor_ready is high.
- sensor_ready  in  1  level; a rising edge marks a new valid reading.
- mem_req  out  1  write request; held high until acked.
- mem_we  out  1  equals mem_req (write-only master).
- mem_addr  out  16  word address; stable while mem_req is high.
- mem_wdata  out  16  write data; stable while mem_req is high.
- mem_ack  in  1  one-cycle acceptance; ignored when mem_req is low.
- irq  out  1  one-cycle pulse after each completed burst.
- overrun  out  1  sticky: a buffered reading was overwritten.
- stale  out  1  no reading for STALE_CYCLES.

Behaviour:
- Reset (reset_n=0 at posedge), all of the following go to 0: mem_req, mem_we, mem_addr, mem_wdata, irq, overrun, stale, ready_q, pending, sample_cnt, valid, stale_timer, stale_reported. State goes to IDLE.
- Edge detect: ready_q <= sensor_ready each cycle; new = sensor_ready & ~ready_q.
  - A reading already held high out of reset is taken once.
- Memory map, data zero-extended:
  - BASE+0 = {8'h00, hum}
  - BASE+1 = {8'h00, tmp}
  - BASE+2 = sample_cnt
  - BASE+3 = {13'b0, stale, overrun, valid}
- Capture (load cap) means:
  - cap <= reading.
  - sample_cnt <= sample_cnt+1, wrapping 16'hFFFF -> 0.
  - valid <= 1; stale_timer <= 0; stale <= 0; stale_reported <= 0.
- States:
  - IDLE:
    - new -> capture sensor_data, go WR_HUM.
    - Else if stale & ~stale_reported -> go WR_STAT (status-only burst).
  - WR_HUM, WR_TMP, WR_CNT, WR_STAT:
    - mem_req=1 with the addr/data for that word, starting the cycle after entry.
    - On the mem_ack cycle, advance: WR_HUM->WR_TMP->WR_CNT->WR_STAT->DONE.
    - mem_req stays high across words; addr/data change the cycle after ack.
    - Minimum 1 cycle per word with ack tied high.
  - WR_STAT ack:
    - overrun <= 0 (reported once).
    - stale_reported <= stale.
    - If new occurs in the same cycle, overrun is set again, since the set wins.
  - DONE (1 cycle):
    - mem_req=0, irq=1.
    - If pending: capture pend, pending <= new, pend <= sensor_data if new; go WR_HUM.
    - Else if new: capture sensor_data, go WR_HUM.
    - Else go IDLE.
- new while busy (any WR_* state):
  - pend <= sensor_data; pending <= 1.
  - If pending was already 1, overrun <= 1 (older buffered reading lost).
- Stale timer:
  - Increments every cycle; saturates at STALE_CYCLES.
  - When it equals STALE_CYCLES, stale <= 1.
  - Reset to 0 on capture.
- Ack rules:
  - mem_ack while mem_req=0 has no effect.
  - There is no timeout: the bridge waits for ack indefinitely while still buffering readings.
- Reset mid-burst: mem_req drops in the same cycle reset is sampled; the partial burst is abandoned and not resumed.

Decomposition:
- Shared package sensor_pkg:
  - Window offsets HUM_OFS=0, TMP_OFS=1, CNT_OFS=2, STAT_OFS=3.
  - Status bit positions VALID_BIT=0, OVERRUN_BIT=1, STALE_BIT=2.
  - State encoding constants.
- One natural sub-module: sensor_stale_timer (saturating counter with clear; outputs the stale level).

Test Plan:
- Single reading: sensor_data=16'h2A19, ready rises, ack tied 1 -> writes FF00=0x002A, FF01=0x0019, FF02=0x0001, FF03=0x0001, one per cycle; irq pulses once; mem_req low afterwards.
- Ack back-pressure: ack delayed 5 cycles per word -> mem_addr/mem_wdata held constant while mem_req is high; same 4 writes in order; no irq until the FF03 ack.
- Buffering and overrun:
  - One new reading 16'h3014 arrives during WR_TMP -> second burst follows DONE directly with count=2, status 0x0001.
  - Two new readings during one burst -> only the last is written; FF03 reports 0x0003; the next burst reports 0x0001.
- Stale: STALE_CYCLES=100, one reading then silence -> at cycle 100 stale=1 and a status-only write FF03=0x0005 occurs exactly once; the next reading clears stale and writes FF03=0x0001.
- Count wrap: preload by driving 65535 readings (or force) -> next burst writes FF02=0x0000.
- Reset mid-burst: reset_n=0 during WR_CNT -> mem_req=0 and all outputs 0 the next cycle; no further writes until a new ready rising edge.
